// File: rtl/conm_mem_arbiter_pkg.sv
// Shared constants for the CoNM unified-SRAM arbiter: reset levels, owner/state codes, helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conm_mem_arbiter_pkg;

    // Reset levels: rst is active-low
    localparam logic RST   = 1'b0;
    localparam logic UNRST = 1'b1;

    localparam int DATA_WIDTH = 32;

    // Owner of the read currently in flight (doubles as the owner FSM encoding)
    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_LS   = 2'd2;

    localparam logic [1:0] ST_IDLE  = OWN_NONE;
    localparam logic [1:0] ST_RD_IF = OWN_IF;
    localparam logic [1:0] ST_RD_LS = OWN_LS;

    // Which requester a grant belongs to
    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LS = 1'b1
    } port_e;

    // Owner code a freshly accepted access leaves pending (writes leave nothing)
    function automatic logic [1:0] next_owner(input logic if_gnt, input logic ls_gnt,
                                              input logic ls_we);
        logic [1:0] own;
        own = OWN_NONE;
        if (ls_gnt && !ls_we) begin
            own = OWN_LS;
        end else if (if_gnt) begin
            own = OWN_IF;
        end
        return own;
    endfunction

endpackage

// File: rtl/conm_mem_arbiter_if.sv
// Bundle of the IF port, LS port and SRAM port around the CoNM memory arbiter.
// Latency: n/a (wiring only).
// Backpressure: req/gnt handshake per requester; the SRAM side never stalls.
interface conm_mem_arbiter_if #(
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int MEMAW = 12
);
    // instruction-fetch port (read only)
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          if_flush;

    // load/store port
    logic          ls_req;
    logic          ls_we;
    logic [AW-1:0] ls_addr;
    logic [3:0]    ls_be;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;

    // single-port SRAM
    logic             mem_ce;
    logic             mem_we;
    logic [MEMAW-1:0] mem_addr;
    logic [3:0]       mem_be;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    mem_rdata;

    // arbiter view
    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  ls_req, ls_we, ls_addr, ls_be, ls_wdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_ce, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata
    );

    // core + SRAM view
    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output ls_req, ls_we, ls_addr, ls_be, ls_wdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_ce, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/conm_rr_pick2.sv
// Two-way round-robin picker: on a conflict the requester that lost the previous conflict wins.
// Latency: grant is combinational from req; pointer updates on the clock after a conflict.
// Backpressure: losing requester simply sees no grant; pointer only moves on conflict cycles.
module conm_rr_pick2
    import conm_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);

    logic prefer0;
    logic enable;
    logic conflict;

    assign enable   = (rst == UNRST);
    assign conflict = req0 && req1;

    // grant: uncontested requests pass, a conflict follows the pointer; nothing during reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (enable) begin
            if (conflict) begin
                gnt0 = prefer0;
                gnt1 = !prefer0;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // pointer: starts preferring port 0, flips to the loser after each conflict
    always_ff @(posedge clk) begin
        if (rst == RST) begin
            prefer0 <= 1'b1;
        end else if (conflict) begin
            prefer0 <= gnt1;
        end
    end

endmodule

// File: rtl/conm_mem_arbiter.sv
// Shares the single-port SRAM between IF and LS; tracks and returns the 1-cycle read (CONM_ARB_RR_EN selects round-robin, else LS-first).
// Latency: grant and SRAM strobe combinational; read data returned exactly one cycle after accept.
// Backpressure: loser of a conflict sees gnt=0 and retries; accepts may issue every cycle.
module conm_mem_arbiter
    import conm_mem_arbiter_pkg::*;
#(
    parameter int AW    = 32,
    parameter int DW    = DATA_WIDTH,
    parameter int MEMAW = 12
)(
    input  logic               clk,
    input  logic               rst,
    conm_mem_arbiter_if.slave  bus
);

    logic       if_gnt_w;
    logic       ls_gnt_w;
    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       unused_addr_bits;

`ifdef CONM_ARB_RR_EN
    conm_rr_pick2 u_pick (
        .clk  (clk),
        .rst  (rst),
        .req0 (bus.if_req),
        .req1 (bus.ls_req),
        .gnt0 (if_gnt_w),
        .gnt1 (ls_gnt_w)
    );
`else
    // fixed priority: LS always wins, IF only when LS is silent; nothing during reset
    always_comb begin
        ls_gnt_w = (rst == UNRST) && bus.ls_req;
        if_gnt_w = (rst == UNRST) && bus.if_req && !bus.ls_req;
    end
`endif

    assign bus.if_gnt = if_gnt_w;
    assign bus.ls_gnt = ls_gnt_w;

    // SRAM port follows whichever requester holds the grant
    always_comb begin
        bus.mem_ce    = if_gnt_w || ls_gnt_w;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
        if (ls_gnt_w) begin
            bus.mem_we    = bus.ls_we;
            bus.mem_addr  = bus.ls_addr[MEMAW+1:2];
            bus.mem_be    = bus.ls_we ? bus.ls_be : 4'b0000;
            bus.mem_wdata = bus.ls_we ? bus.ls_wdata : '0;
        end else if (if_gnt_w) begin
            bus.mem_addr  = bus.if_addr[MEMAW+1:2];
        end
    end

    // owner of the next cycle's read response; writes leave nothing pending
    always_comb begin
        state_nxt = next_owner(if_gnt_w, ls_gnt_w, bus.ls_we);
    end

    // owner FSM: IDLE / RD_IF / RD_LS, rebuilt every cycle from this cycle's accept
    always_ff @(posedge clk) begin
        if (rst == RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // response routing: a flush kills the IF response, reset kills any response in flight
    always_comb begin
        bus.if_rvalid = (rst == UNRST) && (state == ST_RD_IF) && !bus.if_flush;
        bus.ls_rvalid = (rst == UNRST) && (state == ST_RD_LS);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.ls_rdata  = bus.ls_rvalid ? bus.mem_rdata : '0;
    end

    // byte-offset and high address bits are deliberately ignored
    assign unused_addr_bits = ^{bus.if_addr[AW-1:MEMAW+2], bus.if_addr[1:0],
                                bus.ls_addr[AW-1:MEMAW+2], bus.ls_addr[1:0]};

endmodule

// File: tb/tb_conm_mem_arbiter.sv
// Bench for conm_mem_arbiter: SRAM model, spec-level reference model, directed vectors.
// Latency: n/a.
// Backpressure: n/a.
module tb_conm_mem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int MEMAW = 12;
    localparam int NW    = 1 << MEMAW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    conm_mem_arbiter_if #(.AW(AW), .DW(DW), .MEMAW(MEMAW)) bus();

    conm_mem_arbiter #(.AW(AW), .DW(DW), .MEMAW(MEMAW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    function automatic logic [31:0] init_word(input int i);
        return (i == 64) ? 32'h1122_3344 : 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- SRAM model driven only by the mem_* pins ----------------
    logic [31:0] sram [NW];
    logic [31:0] sram_q;
    assign bus.mem_rdata = sram_q;

    initial begin
        for (int i = 0; i < NW; i++) sram[i] <= init_word(i);
        sram_q <= '0;
        forever begin
            @(posedge clk);
            if (bus.mem_ce === 1'b1) begin
                if (bus.mem_we) begin
                    for (int b = 0; b < 4; b++)
                        if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
                end else begin
                    sram_q <= sram[bus.mem_addr];
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    logic [31:0] golden [NW];

    initial begin
        int          pend;       // 0 none, 1 IF, 2 LS
        logic [31:0] pend_dat;
        bit          prefer_if;
        bit          armed;
        bit          e_ig, e_lg, e_iv, e_lv;
        logic [31:0] e_ir, e_lr;
        int unsigned w;
        for (int i = 0; i < NW; i++) golden[i] = init_word(i);
        pend = 0; pend_dat = '0; prefer_if = 1'b1; armed = 1'b0;
        forever begin
            @(negedge clk);
            e_ig = 1'b0;
            e_lg = 1'b0;
            if (rst === 1'b1) begin
                if (bus.if_req && bus.ls_req) begin
`ifdef CONM_ARB_RR_EN
                    if (prefer_if) e_ig = 1'b1; else e_lg = 1'b1;
`else
                    e_lg = 1'b1;
`endif
                end else begin
                    e_ig = bus.if_req;
                    e_lg = bus.ls_req;
                end
            end
            e_iv = (rst === 1'b1) && (pend == 1) && !bus.if_flush;
            e_lv = (rst === 1'b1) && (pend == 2);
            e_ir = e_iv ? pend_dat : 32'h0;
            e_lr = e_lv ? pend_dat : 32'h0;
            if (armed) begin
                chk("m_if_gnt",    bus.if_gnt,    32'(e_ig));
                chk("m_ls_gnt",    bus.ls_gnt,    32'(e_lg));
                chk("m_mem_ce",    bus.mem_ce,    32'(e_ig | e_lg));
                chk("m_if_rvalid", bus.if_rvalid, 32'(e_iv));
                chk("m_ls_rvalid", bus.ls_rvalid, 32'(e_lv));
                chk("m_if_rdata",  bus.if_rdata,  e_ir);
                chk("m_ls_rdata",  bus.ls_rdata,  e_lr);
                if (e_lg) begin
                    chk("m_mem_we_ls",   bus.mem_we,   32'(bus.ls_we));
                    chk("m_mem_addr_ls", bus.mem_addr, 32'(bus.ls_addr[MEMAW+1:2]));
                    if (bus.ls_we) begin
                        chk("m_mem_be",    bus.mem_be,    32'(bus.ls_be));
                        chk("m_mem_wdata", bus.mem_wdata, bus.ls_wdata);
                    end
                end
                if (e_ig) begin
                    chk("m_mem_we_if",   bus.mem_we,   32'h0);
                    chk("m_mem_addr_if", bus.mem_addr, 32'(bus.if_addr[MEMAW+1:2]));
                end
            end
            // advance the model to the next cycle
            if (rst !== 1'b1) begin
                pend = 0;
                prefer_if = 1'b1;
            end else begin
`ifdef CONM_ARB_RR_EN
                if (bus.if_req && bus.ls_req) prefer_if = e_lg;
`endif
                pend = 0;
                if (e_lg) begin
                    w = 32'(bus.ls_addr[MEMAW+1:2]);
                    if (bus.ls_we) begin
                        for (int b = 0; b < 4; b++)
                            if (bus.ls_be[b]) golden[w][8*b +: 8] = bus.ls_wdata[8*b +: 8];
                    end else begin
                        pend = 2;
                        pend_dat = golden[w];
                    end
                end else if (e_ig) begin
                    w = 32'(bus.if_addr[MEMAW+1:2]);
                    pend = 1;
                    pend_dat = golden[w];
                end
            end
            armed = 1'b1;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit ir, input logic [31:0] ia, input bit fl,
                         input bit lr, input bit lw, input logic [31:0] la,
                         input logic [3:0] be, input logic [31:0] wd);
        bus.if_req   = ir;
        bus.if_addr  = ia;
        bus.if_flush = fl;
        bus.ls_req   = lr;
        bus.ls_we    = lw;
        bus.ls_addr  = la;
        bus.ls_be    = be;
        bus.ls_wdata = wd;
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    logic [3:0] t3_ls;
    logic       t5_if;

    initial begin
`ifdef CONM_ARB_RR_EN
        t3_ls = 4'b1010;
        t5_if = 1'b1;
`else
        t3_ls = 4'b1111;
        t5_if = 1'b0;
`endif
        rst = 1'b0;
        drive(1, 32'h0, 0, 1, 0, 32'h4, 4'h0, 32'h0);
        @(negedge clk);
        chk("rst_if_gnt", bus.if_gnt, 32'h0);
        chk("rst_ls_gnt", bus.ls_gnt, 32'h0);
        chk("rst_mem_ce", bus.mem_ce, 32'h0);
        cyc(); idle();
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("rst_if_rvalid", bus.if_rvalid, 32'h0);
        chk("rst_ls_rvalid", bus.ls_rvalid, 32'h0);

        // 1: IF streaming reads of words 0,1,2
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k < 3) drive(1, 32'(4*k), 0, 0, 0, 32'h0, 4'h0, 32'h0); else idle();
            @(negedge clk);
            if (k < 3) chk("t1_if_gnt", bus.if_gnt, 32'h1);
            if (k > 0) begin
                chk("t1_if_rvalid", bus.if_rvalid, 32'h1);
                chk("t1_if_rdata",  bus.if_rdata,  32'(k-1));
            end
        end

        // 2: partial write then read back
        cyc(); drive(0, 32'h0, 0, 1, 1, 32'h100, 4'b0011, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("t2_wr_gnt", bus.ls_gnt, 32'h1);
        cyc(); drive(0, 32'h0, 0, 1, 0, 32'h100, 4'h0, 32'h0);
        @(negedge clk);
        chk("t2_rd_gnt", bus.ls_gnt, 32'h1);
        cyc(); idle();
        @(negedge clk);
        chk("t2_ls_rvalid", bus.ls_rvalid, 32'h1);
        chk("t2_ls_rdata",  bus.ls_rdata,  32'h1122_BEEF);

        // 3: four-cycle conflict
        for (int k = 0; k < 4; k++) begin
            cyc(); drive(1, 32'h10, 0, 1, 0, 32'h20, 4'h0, 32'h0);
            @(negedge clk);
            chk("t3_ls_gnt", bus.ls_gnt, 32'(t3_ls[k]));
            chk("t3_if_gnt", bus.if_gnt, 32'(!t3_ls[k]));
        end

        // 4: flush suppresses the due IF response but not the new request
        cyc(); drive(1, 32'h0C, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        cyc(); drive(1, 32'h14, 1, 0, 0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("t4_flush_rvalid", bus.if_rvalid, 32'h0);
        chk("t4_flush_rdata",  bus.if_rdata,  32'h0);
        chk("t4_flush_gnt",    bus.if_gnt,    32'h1);
        cyc(); idle();
        @(negedge clk);
        chk("t4_if_rvalid", bus.if_rvalid, 32'h1);
        chk("t4_if_rdata",  bus.if_rdata,  32'h5);

        // 6: interleaved IF then LS reads
        cyc(); drive(1, 32'h18, 0, 0, 0, 32'h0, 4'h0, 32'h0);
        cyc(); drive(0, 32'h0, 0, 1, 0, 32'h1C, 4'h0, 32'h0);
        @(negedge clk);
        chk("t6_if_rvalid_n1", bus.if_rvalid, 32'h1);
        chk("t6_if_rdata_n1",  bus.if_rdata,  32'h6);
        chk("t6_ls_rvalid_n1", bus.ls_rvalid, 32'h0);
        cyc(); idle();
        @(negedge clk);
        chk("t6_if_rvalid_n2", bus.if_rvalid, 32'h0);
        chk("t6_ls_rvalid_n2", bus.ls_rvalid, 32'h1);
        chk("t6_ls_rdata_n2",  bus.ls_rdata,  32'h7);

        // 5: reset right after an accepted LS read
        cyc(); drive(0, 32'h0, 0, 1, 0, 32'h24, 4'h0, 32'h0);
        cyc(); rst = 1'b0; drive(1, 32'h28, 0, 1, 0, 32'h2C, 4'h0, 32'h0);
        @(negedge clk);
        chk("t5_ls_rvalid", bus.ls_rvalid, 32'h0);
        chk("t5_ls_gnt",    bus.ls_gnt,    32'h0);
        chk("t5_if_gnt",    bus.if_gnt,    32'h0);
        cyc();
        @(negedge clk);
        chk("t5_mem_ce", bus.mem_ce, 32'h0);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("t5_post_ls_rvalid", bus.ls_rvalid, 32'h0);
        chk("t5_post_if_gnt",    bus.if_gnt,    32'(t5_if));
        chk("t5_post_ls_gnt",    bus.ls_gnt,    32'(!t5_if));
        cyc(); idle();
        @(negedge clk);
        chk("t5_post_rdata", t5_if ? bus.if_rdata : bus.ls_rdata, t5_if ? 32'd10 : 32'd11);

        // patterned mix of requests, writes and flushes, checked by the model
        for (int i = 0; i < 24; i++) begin
            logic [4:0] p;
            p = 5'(i);
            cyc();
            drive(p[0], 32'(4*(32 + i)), p[3], p[1], p[2], 32'(4*(40 + (i % 6))),
                  p[3:0] | 4'b0001, 32'hA500_0000 | 32'(i));
        end
        cyc(); idle();
        cyc();
        cyc();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
